// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave exposing four 32-bit read/write registers, all of them mirrored on REG_OUT.
// The write path is a 4-state FSM that lets AW and W arrive in either order. The read path is a single RVALID flag.
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] REG_OUT,
  output logic [1:0]                      wr_state
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_t;

  wstate_t        state, state_nx;
  logic [DW-1:0]  regs [4];
  logic [1:0]     aw_idx_q;
  logic [DW-1:0]  w_data_q;
  logic [SW-1:0]  w_strb_q;
  logic           rvalid_q;
  logic [DW-1:0]  rdata_q;
  logic           aw_hs, w_hs, ar_hs, commit;
  logic [1:0]     wr_idx;
  logic [DW-1:0]  wr_data;
  logic [SW-1:0]  wr_strb;
  logic           unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A transfer completes on any rising edge where VALID and READY are both high.
  // VALID must be held until that edge. READY may depend on internal state only.
  assign S_AXI_AWREADY = S_AXI_ARESETN & ((state == W_IDLE) | (state == W_DATA));
  assign S_AXI_WREADY  = S_AXI_ARESETN & ((state == W_IDLE) | (state == W_ADDR));
  assign S_AXI_ARREADY = S_AXI_ARESETN & ~rvalid_q;
  assign S_AXI_BVALID  = (state == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign REG_OUT       = {regs[3], regs[2], regs[1], regs[0]};
  assign wr_state      = state;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // The held half is used when the partner handshake arrives later.
  assign wr_idx  = (state == W_ADDR) ? aw_idx_q : S_AXI_AWADDR[3:2];
  assign wr_data = (state == W_DATA) ? w_data_q : S_AXI_WDATA;
  assign wr_strb = (state == W_DATA) ? w_strb_q : S_AXI_WSTRB;

  always_comb begin
    state_nx = state;
    case (state)
      W_IDLE: begin
        if (aw_hs && w_hs) state_nx = W_RESP;
        else if (aw_hs)    state_nx = W_ADDR;
        else if (w_hs)     state_nx = W_DATA;
      end
      W_ADDR: if (w_hs)         state_nx = W_RESP;
      W_DATA: if (aw_hs)        state_nx = W_RESP;
      W_RESP: if (S_AXI_BREADY) state_nx = W_IDLE;
      default:                  state_nx = W_IDLE;
    endcase
  end

  assign commit = (state != W_RESP) && (state_nx == W_RESP);

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state    <= W_IDLE;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        for (int b = 0; b < SW; b++)
          if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // A read that lands on a commit edge samples the register before the write takes effect.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= regs[S_AXI_ARADDR[3:2]];
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: a table of write/readback vectors plus hand-built sequences.
// The sequences cover the split AW/W, back-pressure, same-edge read/write, and mid-write reset cases.
module tb_axi4lite_reg_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp, wr_state;
  logic [127:0] reg_out;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  axi4lite_reg_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG_OUT(reg_out), .wr_state(wr_state)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1; wvalid = 1; bready = 1;
    while (!(aw_done && w_done) && cyc < 20) begin
      #1;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk); @(negedge clk);
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    check("write_handshake_timeout", {126'd0, aw_done, w_done}, 128'd3);
    cyc = 0;
    while (!bvalid && cyc < 20) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    check("write_bvalid", bvalid, 1);
    check("write_bresp", bresp, 0);
    @(posedge clk);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int cyc = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1; rready = 1;
    #1;
    while (!arready && cyc < 20) begin
      @(posedge clk); @(negedge clk); #1;
      cyc++;
    end
    @(posedge clk); @(negedge clk);
    arvalid = 0;
    check("read_rvalid", rvalid, 1);
    check("read_rresp", rresp, 0);
    data = rdata;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
    vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
    vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
    vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
    vecs[4] = '{4'h4, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF};
    vecs[5] = '{4'h4, 32'h1234_5678, 4'h5, 32'hFF34_FF78};
    vecs[6] = '{4'h0, 32'hAAAA_AAAA, 4'h0, 32'h0000_0001};
    vecs[7] = '{4'h9, 32'h0000_0055, 4'hF, 32'h0000_0055};
    vecs[8] = '{4'hB, 32'h1111_1103, 4'h1, 32'h0000_0003};

    // clock/reset
    rst_n = 0; awaddr = 0; araddr = 0; awprot = 3'b101; arprot = 3'b010;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    wdata = 0; wstrb = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_reg_out", reg_out, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_ready", {awready, wready, arready}, 3'b111);

    // table-driven writes, each followed by a readback
    for (int i = 0; i < 9; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      axi_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      if (i == 3)
        check("reg_out_all", reg_out, 128'h00000004_00000003_00000002_00000001);
    end
    check("reg_out_after_table", reg_out, 128'h00000004_00000003_FF34FF78_00000001);

    // AW arrives three cycles ahead of W
    @(negedge clk);
    awaddr = 4'h8; awvalid = 1; bready = 0;
    #1 check("split_awready_pre", awready, 1);
    @(posedge clk); @(negedge clk);
    awvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("split_awready_held", awready, 0);
      check("split_state_addr", wr_state, 2'd1);
      check("split_bvalid_idle", bvalid, 0);
      @(posedge clk); @(negedge clk);
    end
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); @(negedge clk);
    wvalid = 0;
    check("split_bvalid", bvalid, 1);
    check("split_reg2", reg_out[95:64], 32'hDEAD_BEEF);
    bready = 1;
    @(posedge clk); @(negedge clk);
    check("split_bvalid_clear", bvalid, 0);

    // response back-pressure: second write waits for BREADY
    awaddr = 4'h0; wdata = 32'h11; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(posedge clk); @(negedge clk);
    wdata = 32'h22;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", bvalid, 1);
      check("bp_readies", {awready, wready}, 2'b00);
      check("bp_reg0", reg_out[31:0], 32'h11);
      @(posedge clk); @(negedge clk);
    end
    bready = 1;
    @(posedge clk); @(negedge clk);
    check("bp_bvalid_drop", bvalid, 0);
    check("bp_awready_back", awready, 1);
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0;
    check("bp_second_bvalid", bvalid, 1);
    check("bp_second_reg0", reg_out[31:0], 32'h22);
    @(posedge clk); @(negedge clk);
    check("bp_second_done", bvalid, 0);

    // read and write commit to 0xC on one edge
    araddr = 4'hC; arvalid = 1; rready = 1;
    awaddr = 4'hC; wdata = 32'h9; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(posedge clk); @(negedge clk);
    arvalid = 0; awvalid = 0; wvalid = 0;
    check("same_edge_rvalid", rvalid, 1);
    check("same_edge_rdata_old", rdata, 32'h4);
    check("same_edge_bvalid", bvalid, 1);
    @(posedge clk);
    axi_read(4'hC, rd);
    check("same_edge_rdata_new", rd, 32'h9);

    // reset after a lone AW, then W arrives
    @(negedge clk);
    awaddr = 4'h4; awvalid = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0; rst_n = 0;
    @(posedge clk); @(negedge clk);
    check("mid_rst_readies", {awready, wready, arready}, 3'b000);
    rst_n = 1;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); @(negedge clk);
    wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_bvalid", bvalid, 0);
      check("mid_rst_reg_out", reg_out, 0);
      @(posedge clk); @(negedge clk);
    end
    axi_read(4'h4, rd);
    check("mid_rst_reg1", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
